l2_refill_scheduler: RTL and testbench
======================================

L2_REFILL_SCHEDULER -- requirements
Module: l2_refill_scheduler

Interface
REQ-001 The block SHALL have parameter NB_REQ, default 4: number of cache refill requesters sharing one L2 port (2..8).
REQ-002 The block SHALL have parameter FETCH_ADDR_WIDTH, default 32: refill address width.
REQ-003 The block SHALL have parameter REFILL_DATA_WIDTH, default 128: refill line beat width.
REQ-004 The block SHALL have parameter MAX_OUTSTANDING, default 2: maximum granted-but-unanswered L2 transactions (1..4).
REQ-005 The block SHALL have port clk  in  1  clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have ports req_i  in  NB_REQ  and addr_i  in  NB_REQ x FETCH_ADDR_WIDTH: per-requester refill request and address.
REQ-008 The block SHALL have ports gnt_o  out  NB_REQ  and r_valid_o  out  NB_REQ: per-requester grant and response valid.
REQ-009 The block SHALL have port r_data_o  out  REFILL_DATA_WIDTH: response data, broadcast to all requesters.
REQ-010 The block SHALL have L2 ports l2_req_o  out  1, l2_gnt_i  in  1, l2_addr_o  out  FETCH_ADDR_WIDTH, l2_r_valid_i  in  1 and l2_r_data_i  in  REFILL_DATA_WIDTH.
REQ-011 The block SHALL have port err_o  out  1: sticky flag for a response received with no outstanding transaction.

Function
REQ-012 The block SHALL arbitrate round-robin: the priority pointer starts at 0; after each L2 handshake (l2_req_o & l2_gnt_i) the pointer SHALL move to winner+1 mod NB_REQ.
REQ-013 The block SHALL implement a two-state FSM, ARB and LOCK; in ARB the winner is the first asserted req_i at or after the pointer.
REQ-014 In ARB, if l2_req_o is asserted without l2_gnt_i, the block SHALL latch the winner index and go to LOCK.
REQ-015 In LOCK, the block SHALL drive l2_req_o from req_i[locked] only, so the L2 address stays stable.
REQ-016 In LOCK, the block SHALL return to ARB on a handshake, or when req_i[locked] drops (protocol violation; release without grant).
REQ-017 l2_addr_o SHALL equal addr_i[winner] with bits [3:0] forced to 0, combinationally; it SHALL be 0 when l2_req_o is low.
REQ-018 l2_req_o SHALL be asserted when a winner exists and the outstanding count is below MAX_OUTSTANDING; when full it SHALL be low, even if a response pops in the same cycle.
REQ-019 gnt_o[winner] SHALL equal l2_req_o & l2_gnt_i; at most one gnt_o bit SHALL be high per cycle.
REQ-020 On a handshake, the winner index SHALL be pushed into an in-order ID FIFO of depth MAX_OUTSTANDING.
REQ-021 On l2_r_valid_i with the FIFO non-empty, r_valid_o[head] SHALL be high in the same cycle (zero latency) and the head SHALL pop.
REQ-022 r_data_o SHALL equal l2_r_data_i at all times.
REQ-023 Push and pop in the same cycle SHALL leave the count unchanged and preserve order.
REQ-024 On l2_r_valid_i with the FIFO empty, the response SHALL be dropped, no r_valid_o bit SHALL assert, and err_o SHALL set and hold until reset.
REQ-025 The FIFO pointers SHALL wrap modulo MAX_OUTSTANDING, and the count SHALL be $clog2(MAX_OUTSTANDING+1) bits wide.

Reset
REQ-026 While rst_n is low, the FSM SHALL be in ARB, the pointer at 0, the FIFO empty, and err_o 0.
REQ-027 While rst_n is low, gnt_o, r_valid_o, l2_req_o and l2_addr_o SHALL be 0.
REQ-028 A reset mid-transaction SHALL discard all outstanding IDs; responses arriving after reset SHALL be treated per REQ-024.

Structure
REQ-029 Package l2_refill_sched_pkg SHALL hold the state enum (ARB, LOCK), REFILL_ALIGN_BITS=4, and the ID width function $clog2(NB_REQ).
REQ-030 The ID FIFO SHALL be a sub-module named refill_id_fifo (push, pop, full, empty, head); the arbiter and FSM SHALL stay in the top level.

Verification
REQ-031 Scenario: NB_REQ=4, all req_i high, l2_gnt_i always 1, responses after 3 cycles -> grant order 0,1,2,3,0; r_valid_o order matches.
REQ-032 Scenario: req_i[2] high with addr 0x1C00_003F, l2_gnt_i low for 5 cycles, req_i[0] rises in cycle 2 -> l2_addr_o=0x1C00_0030 held stable, gnt_o[2] asserts first.
REQ-033 Scenario: MAX_OUTSTANDING=2, two grants with no response -> l2_req_o low; a response pops requester A; the next cycle l2_req_o reasserts.
REQ-034 Scenario: full FIFO, response and pending request in the same cycle -> no grant that cycle; grant in the following cycle.
REQ-035 Scenario: l2_r_valid_i pulsed with the FIFO empty -> r_valid_o=0 and err_o=1 persisting; after reset err_o=0.
REQ-036 Scenario: rst_n asserted with 1 outstanding -> all outputs 0; the first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/l2_refill_sched_pkg.sv
// Shared types and constants for the L2 refill scheduler.
// Holds the arbiter state enum, the refill line alignment and the ID width helper.
package l2_refill_sched_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int REFILL_ALIGN_BITS = 4;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int id_width(input int nb_req);
    return (nb_req > 1) ? $clog2(nb_req) : 1;
  endfunction

endpackage

// File: rtl/refill_id_fifo.sv
// In-order FIFO of granted requester IDs awaiting their L2 response.
// Depth need not be a power of two; the pointers wrap explicitly.
module refill_id_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_id,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/l2_refill_scheduler.sv
// Round-robin arbiter sharing one L2 refill port among NB_REQ requesters,
// with in-order response routing back to the granted requester.
module l2_refill_scheduler
  import l2_refill_sched_pkg::*;
#(
  parameter int NB_REQ            = 4,
  parameter int FETCH_ADDR_WIDTH  = 32,
  parameter int REFILL_DATA_WIDTH = 128,
  parameter int MAX_OUTSTANDING   = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NB_REQ-1:0]                        req_i,
  input  logic [NB_REQ-1:0][FETCH_ADDR_WIDTH-1:0]  addr_i,
  output logic [NB_REQ-1:0]                        gnt_o,
  output logic [NB_REQ-1:0]                        r_valid_o,
  output logic [REFILL_DATA_WIDTH-1:0]             r_data_o,
  output logic                                     l2_req_o,
  input  logic                                     l2_gnt_i,
  output logic [FETCH_ADDR_WIDTH-1:0]              l2_addr_o,
  input  logic                                     l2_r_valid_i,
  input  logic [REFILL_DATA_WIDTH-1:0]             l2_r_data_i,
  output logic                                     err_o,
  output arb_state_e                               dbg_state
);

  // Handshakes: an L2 transaction is accepted in the cycle l2_req_o & l2_gnt_i
  // are both high; l2_r_valid_i is a single-cycle response with no back-pressure,
  // routed to the oldest outstanding requester in the same cycle.

  localparam int IDW = id_width(NB_REQ);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] lock_q, lock_d;
  logic [IDW-1:0] arb_idx;
  logic           arb_found;
  logic [IDW-1:0] win_idx;
  logic           win_valid;
  logic           req_int;
  logic           handshake;
  logic           fifo_full;
  logic           fifo_empty;
  logic [IDW-1:0] head_id;
  logic           pop;
  logic           err_q;

  // First asserted request at or after the priority pointer.
  always_comb begin
    int cand;
    cand      = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      cand = (int'(ptr_q) + i) % NB_REQ;
      if (!arb_found && req_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = IDW'(cand);
      end
    end
  end

  // Once locked, only the locked requester may drive the L2 request.
  always_comb begin
    win_idx   = arb_idx;
    win_valid = arb_found;
    if (state_q == LOCK) begin
      win_idx   = lock_q;
      win_valid = req_i[lock_q];
    end
  end

  assign req_int   = rst_n & win_valid & ~fifo_full;
  assign handshake = req_int & l2_gnt_i;
  assign pop       = rst_n & l2_r_valid_i & ~fifo_empty;

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    if (handshake) ptr_d = (win_idx == IDW'(NB_REQ - 1)) ? '0 : win_idx + IDW'(1);
    case (state_q)
      ARB: begin
        if (req_int && !l2_gnt_i) begin
          state_d = LOCK;
          lock_d  = win_idx;
        end
      end
      LOCK: begin
        if (handshake || !req_i[lock_q]) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      ptr_q   <= '0;
      lock_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      if (l2_r_valid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  refill_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (IDW)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (handshake),
    .push_id (win_idx),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head_id)
  );

  always_comb begin
    l2_addr_o = '0;
    if (req_int) begin
      l2_addr_o                           = addr_i[win_idx];
      l2_addr_o[REFILL_ALIGN_BITS-1:0]    = '0;
    end
  end

  always_comb begin
    gnt_o     = '0;
    r_valid_o = '0;
    if (handshake) gnt_o[win_idx]     = 1'b1;
    if (pop)       r_valid_o[head_id] = 1'b1;
  end

  assign l2_req_o  = req_int;
  assign r_data_o  = l2_r_data_i;
  assign err_o     = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_l2_refill_scheduler.sv
// Bench for l2_refill_scheduler: directed scenarios plus random traffic against a
// queue-based reference model; grants and responses are checked by a monitor.
module tb_l2_refill_scheduler;
  import l2_refill_sched_pkg::*;

  localparam int NB = 4;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int MO = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NB-1:0]          req_i = '0;
  logic [NB-1:0][AW-1:0]  addr_i;
  logic [NB-1:0]          gnt_o;
  logic [NB-1:0]          r_valid_o;
  logic [DW-1:0]          r_data_o;
  logic                   l2_req_o;
  logic                   l2_gnt_i = 1'b0;
  logic [AW-1:0]          l2_addr_o;
  logic                   l2_r_valid_i = 1'b0;
  logic [DW-1:0]          l2_r_data_i = '0;
  logic                   err_o;
  arb_state_e             dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  l2_refill_scheduler #(
    .NB_REQ(NB), .FETCH_ADDR_WIDTH(AW), .REFILL_DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .addr_i(addr_i), .gnt_o(gnt_o),
    .r_valid_o(r_valid_o), .r_data_o(r_data_o), .l2_req_o(l2_req_o), .l2_gnt_i(l2_gnt_i),
    .l2_addr_o(l2_addr_o), .l2_r_valid_i(l2_r_valid_i), .l2_r_data_i(l2_r_data_i),
    .err_o(err_o), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // scoreboard queues: requester index expected on gnt_o / r_valid_o this cycle
  logic [7:0] exp_gnt_q[$];
  logic [7:0] exp_rsp_q[$];

  // reference model: priority pointer, held requester (-1 none), outstanding IDs, error flag
  int  m_ptr  = 0;
  int  m_lock = -1;
  int  m_out[$];
  bit  m_err  = 1'b0;
  bit  mon_on = 1'b1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // driver: one clock cycle of stimulus, combinational checks, then model update
  task automatic cycle(input logic rst, input logic [NB-1:0] req, input logic gnt, input logic rv);
    int            cand;
    logic          exp_req;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] data;
    bit            hs;
    @(negedge clk);
    data         = {$urandom, $urandom, $urandom, $urandom};
    rst_n        = rst;
    req_i        = req;
    l2_gnt_i     = gnt;
    l2_r_valid_i = rv;
    l2_r_data_i  = data;
    #1;
    if (!rst) begin
      m_ptr = 0; m_lock = -1; m_out.delete(); m_err = 1'b0;
    end
    cand = -1;
    if (rst) begin
      if (m_lock >= 0) begin
        if (req[m_lock]) cand = m_lock;
      end else begin
        for (int k = 0; k < NB; k++) begin
          int c;
          c = (m_ptr + k) % NB;
          if (cand < 0 && req[c]) cand = c;
        end
      end
    end
    exp_req  = (cand >= 0) && (m_out.size() < MO);
    exp_addr = exp_req ? (addr_i[cand] & ~32'hF) : '0;
    hs       = exp_req && gnt;
    chk("l2_req", l2_req_o, exp_req);
    chk("l2_addr", l2_addr_o, exp_addr);
    chk("err", err_o, m_err);
    chk("r_data", r_data_o, data);
    chk("dbg_state", dbg_state, (m_lock >= 0) ? LOCK : ARB);
    if (hs) exp_gnt_q.push_back(8'(cand));
    if (rst && rv && m_out.size() > 0) exp_rsp_q.push_back(8'(m_out[0]));
    if (rst) begin
      if (rv) begin
        if (m_out.size() > 0) void'(m_out.pop_front());
        else m_err = 1'b1;
      end
      if (hs) begin
        m_out.push_back(cand);
        m_ptr = (cand + 1) % NB;
      end
      if (m_lock < 0) begin
        if (exp_req && !gnt) m_lock = cand;
      end else if (hs || !req[m_lock]) begin
        m_lock = -1;
      end
    end
  endtask

  // monitor: compares gnt_o / r_valid_o against the scoreboard queues
  initial begin
    logic [NB-1:0] ev;
    forever begin
      @(negedge clk);
      #2;
      if (!mon_on) break;
      if (gnt_o != '0 || exp_gnt_q.size() != 0) begin
        ev = '0;
        if (exp_gnt_q.size() != 0) ev = NB'(1) << exp_gnt_q.pop_front();
        chk("gnt", gnt_o, ev);
      end
      if (r_valid_o != '0 || exp_rsp_q.size() != 0) begin
        ev = '0;
        if (exp_rsp_q.size() != 0) ev = NB'(1) << exp_rsp_q.pop_front();
        chk("r_valid", r_valid_o, ev);
      end
    end
  end

  initial begin
    for (int i = 0; i < NB; i++) addr_i[i] = $urandom;

    // reset state with all requests high
    cycle(1'b0, 4'hF, 1'b1, 1'b1);
    cycle(1'b0, 4'hF, 1'b1, 1'b0);
    chk("rst_l2_req", l2_req_o, 1'b0);
    chk("rst_gnt", gnt_o, '0);

    // all requesting, L2 always granting, responses from the third cycle on
    for (int i = 0; i < 14; i++) cycle(1'b1, 4'hF, 1'b1, (i >= 3));
    cycle(1'b1, 4'h0, 1'b0, 1'b1);
    cycle(1'b1, 4'h0, 1'b0, 1'b1);

    // held request with unaligned address, L2 stalls, lower requester arrives
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    addr_i[2] = 32'h1C00_003F;
    addr_i[0] = 32'h0000_1234;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, (i >= 2) ? 4'b0101 : 4'b0100, 1'b0, 1'b0);
      chk("lock_addr", l2_addr_o, 32'h1C00_0030);
    end
    cycle(1'b1, 4'b0101, 1'b1, 1'b0);
    chk("lock_first_gnt", gnt_o, 4'b0100);
    cycle(1'b1, 4'b0101, 1'b1, 1'b0);
    chk("lock_second_gnt", gnt_o, 4'b0001);

    // full FIFO: no request even when a response pops in the same cycle
    cycle(1'b1, 4'b0100, 1'b1, 1'b0);
    chk("full_l2_req", l2_req_o, 1'b0);
    cycle(1'b1, 4'b0100, 1'b1, 1'b1);
    chk("full_pop_l2_req", l2_req_o, 1'b0);
    chk("full_pop_rvalid", r_valid_o, 4'b0100);
    cycle(1'b1, 4'b0100, 1'b1, 1'b0);
    chk("after_pop_gnt", gnt_o, 4'b0100);
    cycle(1'b1, 4'h0, 1'b0, 1'b1);
    cycle(1'b1, 4'h0, 1'b0, 1'b1);

    // response with nothing outstanding
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    cycle(1'b1, 4'h0, 1'b0, 1'b1);
    chk("orphan_rvalid", r_valid_o, '0);
    cycle(1'b1, 4'h0, 1'b0, 1'b0);
    chk("err_set", err_o, 1'b1);
    cycle(1'b1, 4'h0, 1'b0, 1'b0);
    chk("err_hold", err_o, 1'b1);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    chk("err_clear", err_o, 1'b0);

    // reset with one transaction outstanding
    cycle(1'b1, 4'b1000, 1'b1, 1'b0);
    cycle(1'b0, 4'hF, 1'b1, 1'b1);
    chk("midrst_outputs", {gnt_o, r_valid_o, l2_req_o, l2_addr_o}, '0);
    cycle(1'b1, 4'hF, 1'b1, 1'b0);
    chk("post_rst_gnt", gnt_o, 4'b0001);
    cycle(1'b1, 4'h0, 1'b0, 1'b1);
    cycle(1'b1, 4'h0, 1'b0, 1'b1);
    chk("post_rst_orphan_err", err_o, 1'b0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if (i % 25 == 0) for (int j = 0; j < NB; j++) addr_i[j] = $urandom;
      cycle(($urandom_range(0, 60) != 0), NB'($urandom_range(0, 15)),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4));
    end

    cycle(1'b1, 4'h0, 1'b0, 1'b0);
    mon_on = 1'b0;
    @(negedge clk);
    #3;
    chk("gnt_q_drained", exp_gnt_q.size(), 0);
    chk("rsp_q_drained", exp_rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
